// File: rtl/invsqrt_nr_pipeline_if.sv
// Valid/ready stream bundle for the inverse square root pipeline.
// The slave view belongs to the pipeline; the master view belongs to the source and sink around it.
interface invsqrt_nr_pipeline_if #(
    parameter int W     = 31,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_special;

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_special
    );

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_special
    );
endinterface

// File: rtl/invsqrt_nr_pipeline.sv
// Fully pipelined fast inverse square root: magic-constant seed followed by NR_ITERS Newton steps.
// The whole pipe advances on one global enable, so a stalled output freezes every stage.
module invsqrt_nr_pipeline #(
    parameter int                         EXP_W    = 8,
    parameter int                         MAN_W    = 23,
    parameter int                         NR_ITERS = 1,
    parameter logic [EXP_W+MAN_W-1:0]     MAGIC    = 31'h5F3759DF,
    parameter int                         TAG_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    invsqrt_nr_pipeline_if.slave bus
);
    localparam int W      = EXP_W + MAN_W;
    localparam int EW     = EXP_W + 2;
    localparam int SW     = MAN_W + 1;
    localparam int STAGES = 4 * NR_ITERS + 1;
    localparam int F      = 2 * MAN_W + 2;

    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] D_MAX  = EW'(F);
    localparam logic [EXP_W-1:0]     EMAX   = '1;
    localparam logic [F:0]           THREE_HALF = (F + 1)'(3) << (F - 1);
    localparam logic [W-1:0]         INF    = {EMAX, {MAN_W{1'b0}}};
    localparam logic [W-1:0]         QNAN   = {EMAX, 1'b1, {(MAN_W - 1){1'b0}}};

    // Internal float: wide signed exponent, significand with explicit hidden bit; s == 0 means zero.
    typedef struct packed {
        logic signed [EW-1:0] e;
        logic [SW-1:0]        s;
    } fl_t;

    typedef struct packed {
        fl_t              x2;
        fl_t              y;
        fl_t              t;
        logic [TAG_W-1:0] tag;
        logic [1:0]       cls;
    } stg_t;

    function automatic fl_t fmul(input fl_t a, input fl_t b);
        logic [2*SW-1:0] p;
        fl_t             r;
        p = {{SW{1'b0}}, a.s} * {{SW{1'b0}}, b.s};
        if (p[2*SW-1]) begin
            r.s = p[2*SW-1 -: SW];
            r.e = a.e + b.e - BIAS + ONE;
        end else begin
            r.s = p[2*SW-2 -: SW];
            r.e = a.e + b.e - BIAS;
        end
        return r;
    endfunction

    // 1.5 - t in fixed point with F fraction bits, then renormalised; t >= 1.5 gives zero.
    function automatic fl_t fsub(input fl_t t);
        logic signed [EW-1:0] d;
        logic [F:0]           tf;
        logic [F:0]           r;
        logic [F:0]           sh;
        int                   p;
        fl_t                  o;
        d  = BIAS - t.e;
        tf = '0;
        r  = '0;
        p  = -1;
        o  = '0;
        if (t.s != '0 && d < 0)
            tf = '1;
        else if (t.s != '0 && d <= D_MAX)
            tf = ({{(F - MAN_W){1'b0}}, t.s} << (F - MAN_W)) >> d;
        if (tf < THREE_HALF)
            r = THREE_HALF - tf;
        for (int i = 0; i <= F; i++)
            if (r[i]) p = i;
        if (p >= 0) begin
            sh  = r << (F - p);
            o.s = sh[F -: SW];
            o.e = BIAS + EW'(p) - D_MAX;
        end
        return o;
    endfunction

    function automatic logic [W-1:0] fpack(input fl_t y, input logic [1:0] cls);
        logic [W-1:0] w;
        case (cls)
            2'b01:   w = INF;
            2'b10:   w = '0;
            2'b11:   w = QNAN;
            default: begin
                if (y.s == '0 || y.e < ONE)
                    w = '0;
                else if (y.e >= EMAX_S)
                    w = INF;
                else
                    w = {y.e[EXP_W-1:0], y.s[MAN_W-1:0]};
            end
        endcase
        return w;
    endfunction

    logic             adv;
    logic [STAGES:0]  vld_pipe;
    stg_t             stg_q [STAGES];
    stg_t             nxt   [STAGES];
    logic [W-1:0]     out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [1:0]       out_special_q;

    logic [EXP_W-1:0] xe;
    logic [MAN_W-1:0] xm;
    logic [W-1:0]     y0w;

    assign adv     = !vld_pipe[STAGES] || bus.out_ready;
    assign xe      = bus.in_data[W-1:MAN_W];
    assign xm      = bus.in_data[MAN_W-1:0];
    assign y0w     = MAGIC - (bus.in_data >> 1);

    assign bus.in_ready    = adv;
    assign bus.out_valid   = vld_pipe[STAGES];
    assign bus.out_data    = out_data_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_special = out_special_q;

    always_comb begin
        for (int k = 0; k < STAGES; k++)
            nxt[k] = '0;

        nxt[0].tag  = bus.in_tag;
        nxt[0].x2.e = $signed({2'b00, xe}) - ONE;
        nxt[0].x2.s = {1'b1, xm};
        nxt[0].y.e  = $signed({2'b00, y0w[W-1:MAN_W]});
        nxt[0].y.s  = {1'b1, y0w[MAN_W-1:0]};
        if (xe == '0)
            nxt[0].cls = 2'b01;
        else if (xe == EMAX)
            nxt[0].cls = (xm == '0) ? 2'b10 : 2'b11;
        else
            nxt[0].cls = 2'b00;

        // Each Newton step: t = x2*y, t = t*y, t = 1.5 - t, y = y*t.
        for (int k = 1; k < STAGES; k++) begin
            nxt[k] = stg_q[k-1];
            case ((k - 1) % 4)
                0:       nxt[k].t = fmul(stg_q[k-1].x2, stg_q[k-1].y);
                1:       nxt[k].t = fmul(stg_q[k-1].t, stg_q[k-1].y);
                2:       nxt[k].t = fsub(stg_q[k-1].t);
                default: nxt[k].y = fmul(stg_q[k-1].y, stg_q[k-1].t);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe      <= '0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
            out_special_q <= '0;
            for (int k = 0; k < STAGES; k++)
                stg_q[k] <= '0;
        end else if (adv) begin
            vld_pipe      <= {vld_pipe[STAGES-1:0], bus.in_valid};
            out_data_q    <= fpack(stg_q[STAGES-1].y, stg_q[STAGES-1].cls);
            out_tag_q     <= stg_q[STAGES-1].tag;
            out_special_q <= stg_q[STAGES-1].cls;
            for (int k = 0; k < STAGES; k++)
                stg_q[k] <= nxt[k];
        end
    end
endmodule
